// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: state codes, opcodes, opcode classes and the
// BranchOp/StackOp encodings shared by the sequencer and the PC update logic.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_ALU_REG = 6'b000000;
    localparam logic [5:0] OP_ALU_IMM = 6'b000001;
    localparam logic [5:0] OP_LD      = 6'b000010;
    localparam logic [5:0] OP_ST      = 6'b000011;
    localparam logic [5:0] OP_BR      = 6'b001000;
    localparam logic [5:0] OP_BPL     = 6'b001001;
    localparam logic [5:0] OP_BMI     = 6'b001010;
    localparam logic [5:0] OP_BZ      = 6'b001011;
    localparam logic [5:0] OP_PUSH    = 6'b010000;
    localparam logic [5:0] OP_POP     = 6'b010001;
    localparam logic [5:0] OP_CALL    = 6'b010010;
    localparam logic [5:0] OP_RET     = 6'b010011;
    localparam logic [5:0] OP_HALT    = 6'b111111;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU_REG, CL_ALU_IMM, CL_LD, CL_ST,
        CL_BR, CL_BPL, CL_BMI, CL_BZ,
        CL_PUSH, CL_POP, CL_CALL, CL_RET, CL_HALT
    } op_class_t;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BPL  = 3'b010;
    localparam logic [2:0] BR_BMI  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;

    localparam logic [2:0] SK_NONE = 3'b000;
    localparam logic [2:0] SK_PUSH = 3'b001;
    localparam logic [2:0] SK_POP  = 3'b010;
    localparam logic [2:0] SK_CALL = 3'b011;
    localparam logic [2:0] SK_RET  = 3'b100;

    function automatic logic [2:0] branch_enc(input op_class_t c);
        case (c)
            CL_BR:   return BR_BR;
            CL_BPL:  return BR_BPL;
            CL_BMI:  return BR_BMI;
            CL_BZ:   return BR_BZ;
            default: return BR_NONE;
        endcase
    endfunction

    // Branch and stack classes are disjoint, so StackOp is only ever
    // nonzero while BranchOp is BR_NONE.
    function automatic logic [2:0] stack_enc(input op_class_t c);
        case (c)
            CL_PUSH: return SK_PUSH;
            CL_POP:  return SK_POP;
            CL_CALL: return SK_CALL;
            CL_RET:  return SK_RET;
            default: return SK_NONE;
        endcase
    endfunction

    function automatic logic needs_mem(input op_class_t c);
        return c inside {CL_LD, CL_ST, CL_PUSH, CL_POP, CL_CALL, CL_RET};
    endfunction

    function automatic logic mem_write(input op_class_t c);
        return c inside {CL_ST, CL_PUSH, CL_CALL};
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the sequencer and the datapath.
//   opcode/mem_ack           : datapath -> sequencer
//   strobes, BranchOp/StackOp,
//   state/halted/mem_err/
//   instr_count              : sequencer -> datapath
// master = sequencer side, slave = datapath side.
interface cpu_sequencer_if;
    logic [5:0]  opcode;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        reg_we;
    logic        pc_we;
    logic        sp_inc;
    logic        sp_dec;
    logic [2:0]  BranchOp;
    logic [2:0]  StackOp;
    logic [2:0]  state;
    logic        halted;
    logic        mem_err;
    logic [31:0] instr_count;

    modport master (
        input  opcode, mem_ack,
        output mem_req, mem_we, ir_we, reg_we, pc_we, sp_inc, sp_dec,
        output BranchOp, StackOp, state, halted, mem_err, instr_count
    );

    modport slave (
        output opcode, mem_ack,
        input  mem_req, mem_we, ir_we, reg_we, pc_we, sp_inc, sp_dec,
        input  BranchOp, StackOp, state, halted, mem_err, instr_count
    );
endinterface

// File: rtl/cpu_sequencer_opcode_decoder.sv
// opcode_decoder: purely combinational opcode -> class mapping.
//   opcode : 6-bit instruction opcode field
//   cls    : decoded class; unlisted opcodes decode to CL_NOP
module opcode_decoder
    import cpu_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);
    always_comb begin
        cls = CL_NOP;
        case (opcode)
            OP_ALU_REG: cls = CL_ALU_REG;
            OP_ALU_IMM: cls = CL_ALU_IMM;
            OP_LD:      cls = CL_LD;
            OP_ST:      cls = CL_ST;
            OP_BR:      cls = CL_BR;
            OP_BPL:     cls = CL_BPL;
            OP_BMI:     cls = CL_BMI;
            OP_BZ:      cls = CL_BZ;
            OP_PUSH:    cls = CL_PUSH;
            OP_POP:     cls = CL_POP;
            OP_CALL:    cls = CL_CALL;
            OP_RET:     cls = CL_RET;
            OP_HALT:    cls = CL_HALT;
            default:    cls = CL_NOP;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer
// (FETCH -> DECODE -> EXEC -> [MEM] -> WB).
//   clk, rst : clock, synchronous active-high reset
//   bus      : cpu_sequencer_if.master -- opcode/mem_ack in; datapath
//              strobes, BranchOp/StackOp, state, halted, sticky mem_err,
//              retired instruction count out.
// A memory phase (FETCH or MEM) that waits MEM_TIMEOUT cycles without
// mem_ack halts the machine with mem_err set.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [WW-1:0] wait_q;
    logic        mem_err_q;
    logic [31:0] cnt_q;
    logic        timeout;
    op_class_t   cls;

    logic mem_req, mem_we, ir_we, reg_we, pc_we, sp_inc, sp_dec;
    logic [2:0] branch_op, stack_op;

    opcode_decoder u_dec (
        .opcode (bus.opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            // Every entry into FETCH/MEM is a state change, so clearing on
            // any change starts each memory phase with a fresh count.
            if (state_d != state_q)
                wait_q <= '0;
            else if (mem_req && !bus.mem_ack)
                wait_q <= wait_q + WW'(1);
            if (timeout)
                mem_err_q <= 1'b1;
            if (state_q == S_WB)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        branch_op = BR_NONE;
        stack_op  = SK_NONE;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                // ack wins over a timeout landing in the same cycle
                if (bus.mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = (cls == CL_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = needs_mem(cls) ? S_MEM : S_WB;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = mem_write(cls);
                if (bus.mem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                reg_we    = cls inside {CL_ALU_REG, CL_ALU_IMM, CL_LD, CL_POP};
                sp_dec    = cls inside {CL_PUSH, CL_CALL};
                sp_inc    = cls inside {CL_POP, CL_RET};
                branch_op = branch_enc(cls);
                stack_op  = stack_enc(cls);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the current state, which still holds its
    // pre-reset value during the reset cycle; gate so reset is quiet.
    assign bus.mem_req     = mem_req & ~rst;
    assign bus.mem_we      = mem_we  & ~rst;
    assign bus.ir_we       = ir_we   & ~rst;
    assign bus.reg_we      = reg_we  & ~rst;
    assign bus.pc_we       = pc_we   & ~rst;
    assign bus.sp_inc      = sp_inc  & ~rst;
    assign bus.sp_dec      = sp_dec  & ~rst;
    assign bus.BranchOp    = rst ? BR_NONE : branch_op;
    assign bus.StackOp     = rst ? SK_NONE : stack_op;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.mem_err     = mem_err_q;
    assign bus.instr_count = cnt_q;

endmodule
